nios_send_framer: RTL and testbench

//  Consumes the 8-bit destination address driven by the Nios send-address PIO,

---
 rtl/nios_send_pkg.sv | 26 ++
 rtl/nios_send_fifo.sv | 55 +++++
 rtl/nios_send_framer.sv | 150 +++++++++++++++
 tb/tb_nios_send_framer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_send_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_send_pkg                                              |
// | Description : Shared types and widths for the Nios send-path framer.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package nios_send_pkg;

    localparam int SEND_ADDR_W = 8;
    localparam int SEND_DATA_W = 32;
    localparam int PKT_W       = SEND_ADDR_W + SEND_DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEND_ADDR_W-1:0] addr;
        logic [SEND_DATA_W-1:0] data;
    } pkt_t;

endpackage

`default_nettype wire

// File: rtl/nios_send_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_send_fifo                                             |
// | Description : Synchronous FIFO with extra-MSB pointers; head shown early.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module nios_send_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en  = push_i && (!full_o || pop_i);
    assign rd_en  = pop_i && !empty_o;
    assign head_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
                wr_ptr_q                   <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nios_send_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_send_framer                                           |
// | Description : Queues PIO {addr,data} on send_go edges and frames them    |
// |               onto a valid/ready link with a minimum inter-packet gap.   |
// |               Define SEND_PARITY_EN to drive even parity on pkt_parity.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module nios_send_framer
    import nios_send_pkg::*;
#(
    parameter int ADDR_W     = SEND_ADDR_W,
    parameter int DATA_W     = SEND_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        send_addr,
    input  logic [DATA_W-1:0]        send_data,
    input  logic                     send_go,
    input  logic                     clr_ovf,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [ADDR_W+DATA_W-1:0] pkt_data,
    output logic                     pkt_parity,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     busy,
    output logic                     overflow
);
    localparam int W     = ADDR_W + DATA_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state_q;
    logic             go_q;
    logic             overflow_q;
    logic             overflow_d;
    logic             pkt_valid_q;
    logic [W-1:0]     pkt_data_q;
    logic [GAP_W-1:0] gap_cnt_q;

    logic             push;
    logic             pop;
    logic             accept;
    logic [W-1:0]     head;

    assign push   = send_go & ~go_q;
    assign pop    = (state_q == IDLE) & ~fifo_empty;
    assign accept = pkt_valid_q & pkt_ready;

    nios_send_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (push),
        .push_data_i ({send_addr, send_data}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A drop on the same edge as clr_ovf keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            go_q       <= send_go;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pkt_data_q  <= head;
                        pkt_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        pkt_valid_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            state_q   <= GAP;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SEND_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^head;
        end else if (accept) begin
            parity_q <= 1'b0;
        end
    end

    assign pkt_parity = parity_q;
`else
    assign pkt_parity = 1'b0;
`endif

    assign pkt_valid = pkt_valid_q;
    assign pkt_data  = pkt_data_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) | ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_nios_send_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nios_send_framer                                        |
// | Description : Directed self-checking bench for nios_send_framer.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_nios_send_framer;

`ifdef SEND_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  send_addr;
    logic [31:0] send_data;
    logic        send_go;
    logic        clr_ovf;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [39:0] pkt_data;
    logic        pkt_parity;
    logic        fifo_full;
    logic        fifo_empty;
    logic        busy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    nios_send_framer #(
        .ADDR_W     (8),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .send_addr  (send_addr),
        .send_data  (send_data),
        .send_go    (send_go),
        .clr_ovf    (clr_ovf),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .pkt_parity (pkt_parity),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] a, input logic [31:0] d);
        send_addr = a;
        send_data = d;
        send_go   = 1'b1;
        tick();
        send_go   = 1'b0;
        tick();
    endtask

    // Waits (bounded) for a packet, checks it, then lets ready=1 accept it.
    task automatic expect_pkt(input string tag, input logic [39:0] exp, input logic exp_par);
        int n = 0;
        while (!pkt_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"},  {63'd0, pkt_valid},  64'd1);
        chk({tag, "_data"},   {24'd0, pkt_data},   {24'd0, exp});
        chk({tag, "_parity"}, {63'd0, pkt_parity}, {63'd0, exp_par});
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [39:0] held;
        logic        held_par;
        int          seen;

        reset     = 1'b1;
        send_addr = '0;
        send_data = '0;
        send_go   = 1'b0;
        clr_ovf   = 1'b0;
        pkt_ready = 1'b0;
        tick();
        tick();

        chk("rst_valid",  {63'd0, pkt_valid},  64'd0);
        chk("rst_data",   {24'd0, pkt_data},   64'd0);
        chk("rst_parity", {63'd0, pkt_parity}, 64'd0);
        chk("rst_full",   {63'd0, fifo_full},  64'd0);
        chk("rst_empty",  {63'd0, fifo_empty}, 64'd1);
        chk("rst_busy",   {63'd0, busy},       64'd0);
        chk("rst_ovf",    {63'd0, overflow},   64'd0);
        reset = 1'b0;
        tick();

        // Single send with immediate acceptance
        pkt_ready = 1'b1;
        send_addr = 8'h2A;
        send_data = 32'hDEADBEEF;
        send_go   = 1'b1;
        tick();
        send_go   = 1'b0;
        chk("t1_push_empty", {63'd0, fifo_empty}, 64'd0);
        chk("t1_push_valid", {63'd0, pkt_valid},  64'd0);
        chk("t1_push_busy",  {63'd0, busy},       64'd1);
        tick();
        chk("t1_pop_valid",  {63'd0, pkt_valid},  64'd1);
        chk("t1_pop_data",   {24'd0, pkt_data},   64'h2ADEADBEEF);
        chk("t1_pop_parity", {63'd0, pkt_parity}, {63'd0, PAR_ON});
        chk("t1_pop_empty",  {63'd0, fifo_empty}, 64'd1);
        tick();
        chk("t1_acc_valid",  {63'd0, pkt_valid},  64'd0);
        chk("t1_acc_parity", {63'd0, pkt_parity}, 64'd0);
        chk("t1_gap1_busy",  {63'd0, busy},       64'd1);
        tick();
        chk("t1_gap2_busy",  {63'd0, busy},       64'd1);
        tick();
        chk("t1_idle_busy",  {63'd0, busy},       64'd0);

        // Backpressure: five cycles of ready=0 after valid
        pkt_ready = 1'b0;
        send_addr = 8'h55;
        send_data = 32'h12345678;
        send_go   = 1'b1;
        tick();
        send_go   = 1'b0;
        tick();
        chk("t2_valid",  {63'd0, pkt_valid},  64'd1);
        chk("t2_data",   {24'd0, pkt_data},   64'h5512345678);
        chk("t2_parity", {63'd0, pkt_parity}, {63'd0, PAR_ON});
        held     = pkt_data;
        held_par = pkt_parity;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid",  {63'd0, pkt_valid},  64'd1);
            chk("t2_hold_data",   {24'd0, pkt_data},   {24'd0, held});
            chk("t2_hold_parity", {63'd0, pkt_parity}, {63'd0, held_par});
        end
        pkt_ready = 1'b1;
        tick();
        chk("t2_acc_valid", {63'd0, pkt_valid}, 64'd0);
        pkt_ready = 1'b0;
        tick();
        tick();
        chk("t2_idle_busy", {63'd0, busy}, 64'd0);

        // Overflow: the first request moves straight to the output register,
        // the next four fill the FIFO and the sixth is dropped.
        for (int i = 0; i < 5; i++) begin
            pulse(8'h10 + 8'(i), 32'hA000_0000 + 32'(i));
        end
        chk("t3_full",       {63'd0, fifo_full}, 64'd1);
        chk("t3_ovf_before", {63'd0, overflow},  64'd0);
        pulse(8'h1F, 32'hFFFF_FFFF);
        chk("t3_ovf_set",    {63'd0, overflow},  64'd1);
        chk("t3_still_full", {63'd0, fifo_full}, 64'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr",    {63'd0, overflow},  64'd0);
        pkt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            held = {8'h10 + 8'(i), 32'hA000_0000 + 32'(i)};
            expect_pkt("t3_drain", held, PAR_ON & (^held));
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pkt_valid) seen++;
        end
        chk("t3_no_extra", 64'(seen), 64'd0);
        chk("t3_empty",    {63'd0, fifo_empty}, 64'd1);
        chk("t3_busy",     {63'd0, busy},       64'd0);

        // Held level: only the rising edge enqueues
        send_addr = 8'h77;
        send_data = 32'h0BAD_F00D;
        send_go   = 1'b1;
        seen      = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 9) send_go = 1'b0;
            if (pkt_valid) seen++;
        end
        chk("t4_one_pkt", 64'(seen), 64'd1);

        // Reset while a packet is stalled and the FIFO holds an overflow
        pkt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(8'h30 + 8'(i), 32'h5A5A_0000 + 32'(i));
        end
        chk("t5_pre_valid", {63'd0, pkt_valid}, 64'd1);
        chk("t5_pre_ovf",   {63'd0, overflow},  64'd1);
        reset = 1'b1;
        tick();
        chk("t5_valid", {63'd0, pkt_valid},  64'd0);
        chk("t5_empty", {63'd0, fifo_empty}, 64'd1);
        chk("t5_full",  {63'd0, fifo_full},  64'd0);
        chk("t5_ovf",   {63'd0, overflow},   64'd0);
        chk("t5_busy",  {63'd0, busy},       64'd0);
        reset     = 1'b0;
        pkt_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pkt_valid) seen++;
        end
        chk("t5_no_pkt", 64'(seen), 64'd0);

        // Parity vector: a single set bit gives odd population
        pulse(8'h01, 32'h0000_0000);
        expect_pkt("t6", 40'h0100000000, PAR_ON);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
